// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared OTTER pipeline types and constants
package cpu_types;

    localparam int OTTER_WB_DEPTH = 3;
    localparam int OTTER_LOAD_LAT = 1;

    typedef logic [$clog2(OTTER_WB_DEPTH+1)-1:0] fwd_sel_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/otter_sb_entry.sv
// rtl/otter_sb_entry.sv - one register's retire/ready countdown pair
module otter_sb_entry #(
    parameter int WB_DEPTH    = 3,
    parameter int ALU_LAT     = 0,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int RC_W        = 2,
    parameter int RDY_W       = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             issue_hit,
    input  logic             issue_is_load,
    input  logic             flush,
    output logic [RC_W-1:0]  retire_cnt,
    output logic [RDY_W-1:0] ready_cnt
);

    // Entries above this retire count are the young stages a flush squashes.
    localparam logic [RC_W-1:0]  FLUSH_THR   = RC_W'(WB_DEPTH - FLUSH_DEPTH);
    localparam logic [RC_W-1:0]  RETIRE_INIT = RC_W'(WB_DEPTH);
    localparam logic [RDY_W-1:0] LOAD_INIT   = RDY_W'(LOAD_LAT);
    localparam logic [RDY_W-1:0] ALU_INIT    = RDY_W'(ALU_LAT);

    // Flush squash beats issue (issue is already gated by flush), issue beats decrement.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            retire_cnt <= '0;
            ready_cnt  <= '0;
        end else if (flush && (retire_cnt > FLUSH_THR)) begin
            retire_cnt <= '0;
            ready_cnt  <= '0;
        end else if (issue_hit) begin
            retire_cnt <= RETIRE_INIT;
            ready_cnt  <= issue_is_load ? LOAD_INIT : ALU_INIT;
        end else begin
            if (retire_cnt != '0) retire_cnt <= retire_cnt - RC_W'(1);
            if (ready_cnt != '0)  ready_cnt  <= ready_cnt - RDY_W'(1);
        end
    end

endmodule

// File: rtl/otter_decode_scoreboard.sv
// rtl/otter_decode_scoreboard.sv - decode-stage hazard scoreboard with stall and forwarding select
module otter_decode_scoreboard
    import cpu_types::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int WB_DEPTH    = OTTER_WB_DEPTH,
    parameter int ALU_LAT     = 0,
    parameter int LOAD_LAT    = OTTER_LOAD_LAT,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32,
    parameter int FSW         = $clog2(WB_DEPTH+1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_rd_used,
    input  logic              issue_is_load,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              flush,
    output logic              stall,
    output logic [FSW-1:0]    fwd_sel_a,
    output logic [FSW-1:0]    fwd_sel_b,
    output logic [NUM_REGS-1:0] busy,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int RDY_MAX = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
    localparam int RDY_W   = (RDY_MAX < 1) ? 1 : $clog2(RDY_MAX+1);

    logic [FSW-1:0]   retire_cnt [NUM_REGS];
    logic [RDY_W-1:0] ready_cnt  [NUM_REGS];

    logic rs1_live;
    logic rs2_live;
    logic issue_ok;

    // x0 is hard-wired: never busy, never forwarded, never stalls.
    assign retire_cnt[0] = '0;
    assign ready_cnt[0]  = '0;
    assign busy[0]       = 1'b0;

    // One counter pair per architectural register except x0.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        otter_sb_entry #(
            .WB_DEPTH    (WB_DEPTH),
            .ALU_LAT     (ALU_LAT),
            .LOAD_LAT    (LOAD_LAT),
            .FLUSH_DEPTH (FLUSH_DEPTH),
            .RC_W        (FSW),
            .RDY_W       (RDY_W)
        ) u_entry (
            .CLK           (CLK),
            .RST_N         (RST_N),
            .issue_hit     (issue_ok && (issue_rd == ADDR_W'(r))),
            .issue_is_load (issue_is_load),
            .flush         (flush),
            .retire_cnt    (retire_cnt[r]),
            .ready_cnt     (ready_cnt[r])
        );
        assign busy[r] = (retire_cnt[r] != '0);
    end

    assign rs1_live = rs1_used && (rs1_addr != '0);
    assign rs2_live = rs2_used && (rs2_addr != '0);

    // Hazard detection and forwarding select are purely combinational on the decode sources.
    always_comb begin
        stall     = 1'b0;
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        if (issue_valid && !flush &&
            ((rs1_live && (ready_cnt[rs1_addr] != '0)) ||
             (rs2_live && (ready_cnt[rs2_addr] != '0)))) begin
            stall = 1'b1;
        end
        if (rs1_live) fwd_sel_a = retire_cnt[rs1_addr];
        if (rs2_live) fwd_sel_b = retire_cnt[rs2_addr];
    end

    assign issue_ok = issue_valid && !stall && !flush && issue_rd_used && (issue_rd != '0);

    // Saturating count of cycles spent stalled.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_otter_decode_scoreboard.sv
// tb/tb_otter_decode_scoreboard.sv - directed table-driven bench for the decode scoreboard
module tb_otter_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_rd_used;
    logic        issue_is_load;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic        flush;

    logic        stall;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [31:0] busy;
    logic [31:0] stall_count;

    logic        stall_s;
    logic [4:0]  fwd_sel_a_s;
    logic [4:0]  fwd_sel_b_s;
    logic [31:0] busy_s;
    logic [3:0]  stall_count_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    otter_decode_scoreboard u_dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rd_used (issue_rd_used),
        .issue_is_load (issue_is_load),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .flush         (flush),
        .stall         (stall),
        .fwd_sel_a     (fwd_sel_a),
        .fwd_sel_b     (fwd_sel_b),
        .busy          (busy),
        .stall_count   (stall_count)
    );

    otter_decode_scoreboard #(
        .WB_DEPTH (24),
        .LOAD_LAT (20),
        .CNT_W    (4)
    ) u_sat (
        .CLK           (clk),
        .RST_N         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rd_used (issue_rd_used),
        .issue_is_load (issue_is_load),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .flush         (flush),
        .stall         (stall_s),
        .fwd_sel_a     (fwd_sel_a_s),
        .fwd_sel_b     (fwd_sel_b_s),
        .busy          (busy_s),
        .stall_count   (stall_count_s)
    );

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rdu;
        logic       ld;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       fl;
        logic       es;
        logic [1:0] efa;
        logic [1:0] efb;
        logic [4:0] breg;
        logic       eb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int v, input int rd, input int rdu, input int ld,
                                input int rs1, input int u1, input int rs2, input int u2,
                                input int fl, input int es, input int efa, input int efb,
                                input int breg, input int eb);
        vec_t r;
        r.v = 1'(v);     r.rd = 5'(rd);   r.rdu = 1'(rdu); r.ld = 1'(ld);
        r.rs1 = 5'(rs1); r.u1 = 1'(u1);   r.rs2 = 5'(rs2); r.u2 = 1'(u2);
        r.fl = 1'(fl);   r.es = 1'(es);   r.efa = 2'(efa); r.efb = 2'(efb);
        r.breg = 5'(breg); r.eb = 1'(eb);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0; issue_rd_used = 1'b0; issue_is_load = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0; flush = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fields: v rd rdu ld | rs1 u1 rs2 u2 fl | exp stall fwd_a fwd_b | busy reg, exp bit
        tbl.push_back(mk(1, 5,1,0,  0,0,0,0,0,  0,0,0,  5,0));
        tbl.push_back(mk(1, 0,0,0,  5,1,0,0,0,  0,3,0,  5,1));
        tbl.push_back(mk(1, 0,0,0,  5,1,0,0,0,  0,2,0,  5,1));
        tbl.push_back(mk(1, 0,0,0,  5,1,0,0,0,  0,1,0,  5,1));
        tbl.push_back(mk(1, 0,0,0,  5,1,0,0,0,  0,0,0,  5,0));
        tbl.push_back(mk(1, 7,1,1,  0,0,0,0,0,  0,0,0,  7,0));
        tbl.push_back(mk(1,10,1,0,  0,0,7,1,0,  1,0,3,  7,1));
        tbl.push_back(mk(1, 0,0,0,  0,0,7,1,0,  0,0,2, 10,0));
        tbl.push_back(mk(0, 0,0,0,  0,0,0,0,0,  0,0,0,  7,1));
        tbl.push_back(mk(0, 0,0,0,  0,0,0,0,0,  0,0,0,  7,0));
        tbl.push_back(mk(1, 9,1,1,  0,0,0,0,0,  0,0,0,  9,0));
        tbl.push_back(mk(1, 9,1,0,  0,0,0,0,0,  0,0,0,  9,1));
        tbl.push_back(mk(1, 0,0,0,  9,1,0,0,0,  0,3,0,  9,1));
        tbl.push_back(mk(0, 0,0,0,  0,0,0,0,0,  0,0,0,  9,1));
        tbl.push_back(mk(0, 0,0,0,  0,0,0,0,0,  0,0,0,  9,1));
        tbl.push_back(mk(0, 0,0,0,  0,0,0,0,0,  0,0,0,  9,0));
        tbl.push_back(mk(1, 2,1,0,  0,0,0,0,0,  0,0,0,  2,0));
        tbl.push_back(mk(1, 3,1,0,  0,0,0,0,0,  0,0,0,  3,0));
        tbl.push_back(mk(1, 4,1,1,  0,0,0,0,0,  0,0,0,  4,0));
        tbl.push_back(mk(1, 6,1,0,  4,1,3,1,1,  0,3,2,  2,1));
        tbl.push_back(mk(1, 0,0,0,  2,1,3,1,0,  0,0,0,  4,0));
        tbl.push_back(mk(0, 0,0,0,  0,0,0,0,0,  0,0,0,  6,0));
        tbl.push_back(mk(1, 0,1,0,  0,0,0,0,0,  0,0,0,  0,0));
        tbl.push_back(mk(1, 0,0,0,  0,1,0,1,0,  0,0,0,  0,0));
        tbl.push_back(mk(1, 8,1,1,  0,0,0,0,0,  0,0,0,  8,0));
        tbl.push_back(mk(1, 0,0,0,  8,0,8,0,0,  0,0,0,  8,1));
        tbl.push_back(mk(1, 0,0,0,  8,1,0,0,0,  0,2,0,  8,1));

        // Reset held two cycles while decode presents a writer to x5.
        idle_inputs();
        rst_n = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_used = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        chk("reset_busy", int'(busy), 0);
        chk("reset_stall", int'(stall), 0);
        chk("reset_stall_count", int'(stall_count), 0);
        chk("reset_fwd_a", int'(fwd_sel_a), 0);

        // Cycle-by-cycle vectors: drive after the edge, sample at mid-cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            issue_valid   = tbl[i].v;
            issue_rd      = tbl[i].rd;
            issue_rd_used = tbl[i].rdu;
            issue_is_load = tbl[i].ld;
            rs1_addr      = tbl[i].rs1;
            rs1_used      = tbl[i].u1;
            rs2_addr      = tbl[i].rs2;
            rs2_used      = tbl[i].u2;
            flush         = tbl[i].fl;
            #4;
            chk($sformatf("row%0d_stall", i), int'(stall), int'(tbl[i].es));
            chk($sformatf("row%0d_fwd_a", i), int'(fwd_sel_a), int'(tbl[i].efa));
            chk($sformatf("row%0d_fwd_b", i), int'(fwd_sel_b), int'(tbl[i].efb));
            chk($sformatf("row%0d_busy%0d", i, tbl[i].breg), int'(busy[tbl[i].breg]), int'(tbl[i].eb));
            next_cycle();
        end
        idle_inputs();
        #4;
        chk("busy_x0_after_table", int'(busy[0]), 0);
        chk("stall_count_after_table", int'(stall_count), 1);

        // Reset in the middle of operation drops pending writers.
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd11; issue_rd_used = 1'b1; issue_is_load = 1'b1;
        next_cycle();
        idle_inputs();
        chk("midreset_pre_busy11", int'(busy[11]), 1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_busy_sat", int'(busy_s), 0);
        chk("midreset_stall_count", int'(stall_count), 0);
        chk("midreset_stall_count_sat", int'(stall_count_s), 0);

        // Long load latency on the 4-bit-counter instance gives 20 stalled cycles.
        issue_valid = 1'b1; issue_rd = 5'd12; issue_rd_used = 1'b1; issue_is_load = 1'b1;
        next_cycle();
        idle_inputs();
        issue_valid = 1'b1; rs1_addr = 5'd12; rs1_used = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #4;
            chk($sformatf("sat_stall_cycle%0d", i), int'(stall_s), 1);
            next_cycle();
        end
        #4;
        chk("sat_stall_released", int'(stall_s), 0);
        chk("sat_stall_count", int'(stall_count_s), 15);
        chk("sat_fwd_a", int'(fwd_sel_a_s), 4);
        chk("main_stall_count_after_sat", int'(stall_count), 1);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otter_decode_scoreboard.md
Name: otter_decode_scoreboard

Overview:
- Parametrised hazard scoreboard for the OTTER pipeline decode stage.
- Tracks every in-flight register writer with per-register countdowns.
- Drives the decode stall (generalised load-use hazard) and a per-operand forwarding select.
- Squashes in-flight writers on a branch/jump flush; counts stall cycles.
- Replaces a fixed single-cycle load-use check with configurable depth and latencies.

Parameters:
- NUM_REGS, 32, architectural registers; x0 is never tracked.
- ADDR_W, 5, register address width; equals clog2(NUM_REGS).
- WB_DEPTH, 3, pipeline stages from issue (decode->execute) to register-file write.
- ALU_LAT, 0, extra cycles after issue before a non-load result is forwardable.
- LOAD_LAT, 1, extra cycles after issue before load data is forwardable; must be less than WB_DEPTH.
- FLUSH_DEPTH, 2, number of youngest in-flight stages squashed by flush.
- CNT_W, 32, stall counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- issue_valid  in  1  decode instruction is valid and would advance this cycle.
- issue_rd  in  ADDR_W  destination register of the decode instruction.
- issue_rd_used  in  1  decode instruction writes rd.
- issue_is_load  in  1  decode instruction is a LOAD.
- rs1_addr, rs2_addr  in  ADDR_W each  source registers of the decode instruction.
- rs1_used, rs2_used  in  1 each  source registers are actually read.
- flush  in  1  taken jump/branch; squash the younger in-flight writers.
- stall  out  1  hold fetch/decode; insert a bubble into execute.
- fwd_sel_a, fwd_sel_b  out  clog2(WB_DEPTH+1)  0 = register file; k = writer that writes the RF in k cycles.
- busy  out  NUM_REGS  per-register pending-write vector.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Per-register state: retire_cnt (0..WB_DEPTH) and ready_cnt (0..LOAD_LAT). busy[r] = (retire_cnt[r] != 0). Register 0 is tied to zero.
- Reset: when RST_N is low at a CLK edge, all counters, busy and stall_count are cleared to 0. Outputs are combinational from cleared state, so stall=0 and fwd_sel_a/fwd_sel_b=0. Reset mid-operation discards all pending entries.
- Every cycle, each nonzero retire_cnt and ready_cnt decrements by 1.
- Stall (combinational):
  - stall = issue_valid && !flush && ((rs1_used && rs1_addr!=0 && ready_cnt[rs1]!=0) || (rs2_used && rs2_addr!=0 && ready_cnt[rs2]!=0)).
- Forwarding (combinational):
  - fwd_sel_a = retire_cnt[rs1_addr] when rs1_used and rs1_addr!=0, else 0. fwd_sel_b is the same for rs2.
  - Valid only when stall=0.
- Issue:
  - Condition: issue_valid && !stall && !flush && issue_rd_used && issue_rd!=0.
  - At the edge: retire_cnt[rd] <= WB_DEPTH; ready_cnt[rd] <= issue_is_load ? LOAD_LAT : ALU_LAT.
  - This overrides the decrement for that register. WAW: the youngest writer replaces the older entry.
- Flush:
  - At the edge, every register with retire_cnt > WB_DEPTH-FLUSH_DEPTH (before decrement) has both counters cleared.
  - The same-cycle issue is suppressed and stall is forced to 0.
  - Older entries continue to count down normally.
- stall_count increments on each cycle with stall=1 and saturates at all-ones.
- Latency:
  - stall and fwd_sel respond combinationally to the source inputs.
  - Scoreboard updates are visible in the cycle after the issue edge.

Decomposition:
- Shared package cpu_types gains:
  - fwd_sel_t typedef.
  - Constants OTTER_WB_DEPTH and OTTER_LOAD_LAT.
  - Enum for forwarding sources: FWD_RF=0, FWD_WB=1, FWD_MEM=2, FWD_EX=3.
- One sub-module, otter_sb_entry: a single register's counter pair with issue/flush/decrement logic. It is instantiated NUM_REGS-1 times via generate.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with issue_valid=1 and issue_rd=5 -> busy=0, stall=0 and stall_count=0 after release.
- ALU back-to-back: issue ADD rd=5, then decode rs1=5 -> stall=0 and fwd_sel_a=3. The next cycles give fwd_sel_a=2, then 1, then 0.
- Load-use: issue LOAD rd=7, then decode rs2=7 -> stall=1 for exactly 1 cycle, then fwd_sel_b=2; stall_count=1.
- WAW: issue LOAD rd=9, then ADDI rd=9, then decode rs1=9 -> stall=0 and fwd_sel_a=3, tracking the younger ALU writer.
- Flush: issue LOAD rd=4, then assert flush -> busy[4]=0 next cycle. An older entry at retire_cnt=1 still retires normally.
- x0 and saturation: issue rd=0 -> busy unchanged. With CNT_W=4, 20 consecutive stall cycles -> stall_count=15.
